// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module  : bin_to_bcd_seq_if                                              |
// | Brief   : Request/result bundle between switch logic and the sequential  |
// |           binary-to-BCD converter.                                       |
// | Rev     : 1.0  initial release                                           |
// ----------------------------------------------------------------------------
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 13,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  // Requester side: issues start/bin_in, observes status and result
  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd,
    input  ovf
  );

  // Converter side
  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd,
    output ovf
  );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module  : bin_to_bcd_seq                                                 |
// | Brief   : Sequential double-dabble converter, one bit per clock.         |
// |           Registered bcd/ovf hold the last complete result so the        |
// |           display never sees a partial conversion.                       |
// | Rev     : 1.0  initial release                                           |
// ----------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int BIN_W  = 13,
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  bin_to_bcd_seq_if.slave      bus
);

  localparam int c_bcd_w = 4 * DIGITS;
  localparam int c_cnt_w = $clog2(BIN_W + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(BIN_W);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_busy;
  logic                 w_done;

  logic [BIN_W-1:0]     r_bin;
  logic [c_bcd_w-1:0]   r_bcd_work;
  logic                 r_ovf_work;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_bcd_w-1:0]   r_bcd;
  logic                 r_ovf;

  logic [c_bcd_w-1:0]   w_adj;
  logic [c_bcd_w-1:0]   w_bcd_shift;
  logic                 w_ovf_shift;

  // Add-3 correction: every nibble >= 5 is bumped so the coming shift carries
  // correctly into the next decimal digit.
  always_comb begin
    w_adj = r_bcd_work;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd_work[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd_work[4*i +: 4] + 4'd3;
      end
    end
  end

  // One shift step; the bit leaving the top digit means the value does not fit
  // in DIGITS decimal digits, so it is latched into the overflow flag.
  always_comb begin
    w_bcd_shift = {w_adj[c_bcd_w-2:0], r_bin[BIN_W-1]};
    w_ovf_shift = r_ovf_work | w_adj[c_bcd_w-1];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and status decode
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        if (r_cnt == c_cnt_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: capture on accepted start, iterate in SHIFT, publish the result
  // on the final iteration so bcd/ovf are already valid while done is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin      <= '0;
      r_bcd_work <= '0;
      r_ovf_work <= 1'b0;
      r_cnt      <= '0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_bin      <= bus.bin_in;
            r_bcd_work <= '0;
            r_ovf_work <= 1'b0;
            r_cnt      <= c_cnt_init;
          end
        end
        S_SHIFT: begin
          r_bin      <= {r_bin[BIN_W-2:0], 1'b0};
          r_bcd_work <= w_bcd_shift;
          r_ovf_work <= w_ovf_shift;
          r_cnt      <= r_cnt - 1'b1;
          if (r_cnt == c_cnt_last) begin
            r_bcd <= w_bcd_shift;
            r_ovf <= w_ovf_shift;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.bcd  = r_bcd;
  assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module  : tb_bin_to_bcd_seq                                              |
// | Brief   : Directed, table-driven bench for bin_to_bcd_seq (4-digit and   |
// |           2-digit instances).                                            |
// | Rev     : 1.0  initial release                                           |
// ----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(13), .DIGITS(4)) ifa ();
  bin_to_bcd_seq_if #(.BIN_W(13), .DIGITS(2)) ifb ();

  bin_to_bcd_seq #(.BIN_W(13), .DIGITS(4)) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (ifa.slave)
  );

  bin_to_bcd_seq #(.BIN_W(13), .DIGITS(2)) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (ifb.slave)
  );

  typedef struct {
    logic [12:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [12:0] bin;
    logic [7:0]  bcd;
    logic        ovf;
    logic        chk_bcd;
  } vec2_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Start one conversion on the 4-digit instance (called at a negedge, DUT idle)
  task automatic conv_a(input logic [12:0] v, output logic [15:0] r, output logic o,
                        output int lat, output int bcnt, output logic fall_ok);
    ifa.start  = 1'b1;
    ifa.bin_in = v;
    lat  = 0;
    bcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ifa.start = 1'b0;
      lat++;
      if (ifa.busy) bcnt++;
      if (ifa.done) break;
    end
    r = ifa.bcd;
    o = ifa.ovf;
    @(negedge clk);
    fall_ok = !ifa.done && !ifa.busy;
  endtask

  task automatic conv_b(input logic [12:0] v, output logic [7:0] r, output logic o,
                        output int lat);
    ifb.start  = 1'b1;
    ifb.bin_in = v;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ifb.start = 1'b0;
      lat++;
      if (ifb.done) break;
    end
    r = ifb.bcd;
    o = ifb.ovf;
    @(negedge clk);
  endtask

  vec_t  vt [8];
  vec2_t vb [5];

  initial begin
    logic [15:0] r;
    logic [7:0]  r2;
    logic        o;
    logic        fall_ok;
    int          lat;
    int          bcnt;
    int          ndone;
    logic [15:0] got;

    vt[0] = '{13'd13,   16'h0013, 1'b0};
    vt[1] = '{13'd241,  16'h0241, 1'b0};
    vt[2] = '{13'd765,  16'h0765, 1'b0};
    vt[3] = '{13'd8191, 16'h8191, 1'b0};
    vt[4] = '{13'd0,    16'h0000, 1'b0};
    vt[5] = '{13'd1000, 16'h1000, 1'b0};
    vt[6] = '{13'd5,    16'h0005, 1'b0};
    vt[7] = '{13'd4095, 16'h4095, 1'b0};

    vb[0] = '{13'd150, 8'h00, 1'b1, 1'b0};
    vb[1] = '{13'd99,  8'h99, 1'b0, 1'b1};
    vb[2] = '{13'd100, 8'h00, 1'b1, 1'b0};
    vb[3] = '{13'd0,   8'h00, 1'b0, 1'b1};
    vb[4] = '{13'd42,  8'h42, 1'b0, 1'b1};

    rst        = 1'b1;
    ifa.start  = 1'b0;
    ifa.bin_in = '0;
    ifb.start  = 1'b0;
    ifb.bin_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, ifa.busy}, 32'd0);
    chk("reset_done", {31'd0, ifa.done}, 32'd0);
    chk("reset_bcd",  {16'd0, ifa.bcd},  32'd0);
    chk("reset_ovf",  {31'd0, ifa.ovf},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table of conversions on the 4-digit instance
    for (int i = 0; i < 8; i++) begin
      conv_a(vt[i].bin, r, o, lat, bcnt, fall_ok);
      chk($sformatf("vec%0d_bcd", i),  {16'd0, r}, {16'd0, vt[i].bcd});
      chk($sformatf("vec%0d_ovf", i),  {31'd0, o}, {31'd0, vt[i].ovf});
      chk($sformatf("vec%0d_lat", i),  lat,  32'd14);
      chk($sformatf("vec%0d_busy", i), bcnt, 32'd14);
      chk($sformatf("vec%0d_fall", i), {31'd0, fall_ok}, 32'd1);
    end
    // last result is 4095

    // start while busy, bin_in changing mid-run, start during DONE: all ignored
    ifa.start  = 1'b1;
    ifa.bin_in = 13'd241;
    ndone = 0;
    got   = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      ifa.start = 1'b0;
      if (ifa.done) begin
        ndone++;
        got = ifa.bcd;
      end
      if (c == 5)  begin ifa.start = 1'b1; ifa.bin_in = 13'd765; end
      if (c == 8)  ifa.bin_in = 13'd13;
      if (c == 10) chk("hold_bcd_midrun", {16'd0, ifa.bcd}, 32'h4095);
      if (c == 14) ifa.start = 1'b1;
    end
    chk("ignore_done_count", ndone, 32'd1);
    chk("ignore_bcd", {16'd0, got}, 32'h0241);
    chk("ignore_idle_after", {31'd0, ifa.busy}, 32'd0);

    // async reset mid-conversion
    ifa.start  = 1'b1;
    ifa.bin_in = 13'd241;
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("areset_busy", {31'd0, ifa.busy}, 32'd0);
    chk("areset_done", {31'd0, ifa.done}, 32'd0);
    chk("areset_bcd",  {16'd0, ifa.bcd},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (ifa.done || ifa.busy) ndone++;
    end
    chk("areset_no_activity", ndone, 32'd0);
    conv_a(13'd765, r, o, lat, bcnt, fall_ok);
    chk("after_reset_bcd", {16'd0, r}, 32'h0765);
    chk("after_reset_lat", lat, 32'd14);

    // start held high: back-to-back, one result per 15 cycles
    ifa.start  = 1'b1;
    ifa.bin_in = 13'd13;
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ifa.done) break;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      lat++;
      if (ifa.done) break;
    end
    chk("b2b_period", lat, 32'd15);
    chk("b2b_bcd", {16'd0, ifa.bcd}, 32'h0013);
    ifa.start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!ifa.busy) break;
    end
    chk("b2b_idle", {31'd0, ifa.busy}, 32'd0);

    // 2-digit instance: overflow detection
    for (int i = 0; i < 5; i++) begin
      conv_b(vb[i].bin, r2, o, lat);
      chk($sformatf("d2_vec%0d_ovf", i), {31'd0, o}, {31'd0, vb[i].ovf});
      chk($sformatf("d2_vec%0d_lat", i), lat, 32'd14);
      if (vb[i].chk_bcd)
        chk($sformatf("d2_vec%0d_bcd", i), {24'd0, r2}, {24'd0, vb[i].bcd});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
